// File: rtl/rtu_sync.sv
// Clocked routing calculation unit: XY (or YX with RTU_YX_ROUTING_EN) route per
// head flit, held per VC until tail, emitted through one valid/ready output stage.
module rtu_sync #(
  parameter int VCN = 2,
  parameter int AW  = 8,
  parameter int DW  = 32,
  parameter int DIR = 0
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic [AW-1:0]  cur_x,
  input  logic [AW-1:0]  cur_y,
  input  logic           in_vld,
  output logic           in_rdy,
  input  logic [VCN-1:0] in_vc,
  input  logic [1:0]     in_ft,
  input  logic [DW-1:0]  in_data,
  output logic           out_vld,
  input  logic           out_rdy,
  output logic [VCN-1:0] out_vc,
  output logic [1:0]     out_ft,
  output logic [DW-1:0]  out_data,
  output logic [4:0]     out_port,
  output logic           err,
  output logic [VCN-1:0] vc_busy
);

  typedef enum logic {VC_IDLE, VC_BUSY} vc_state_e;
  typedef enum logic [1:0] {FT_BODY, FT_HEAD, FT_TAIL, FT_SINGLE} ft_e;

  localparam logic [4:0] P_S = 5'b00001;
  localparam logic [4:0] P_W = 5'b00010;
  localparam logic [4:0] P_N = 5'b00100;
  localparam logic [4:0] P_E = 5'b01000;
  localparam logic [4:0] P_L = 5'b10000;
  // Port that would send the flit back where it came from; for the local input
  // this is L itself, so one compare covers both U-turn and local-to-local.
  localparam logic [4:0] DIR_PORT = (DIR < 4) ? (P_S << DIR) : P_L;

  vc_state_e  state_q [VCN];
  vc_state_e  state_d [VCN];
  logic [4:0] route_q [VCN];

  logic [AW-1:0] dx, dy;
  logic [4:0]    raw_port, calc_port, held_port, sel_port;
  logic          route_err, vc_ok, xfer, cur_busy;
  logic          emit, bad, store, next_busy;

  assign dx     = in_data[AW-1:0];
  assign dy     = in_data[2*AW-1:AW];
  assign in_rdy = ~out_vld | out_rdy;
  assign xfer   = in_vld & in_rdy;
  assign vc_ok  = $onehot(in_vc);

  always_comb begin
    raw_port = P_L;
`ifdef RTU_YX_ROUTING_EN
    if (dy > cur_y)      raw_port = P_N;
    else if (dy < cur_y) raw_port = P_S;
    else if (dx > cur_x) raw_port = P_E;
    else if (dx < cur_x) raw_port = P_W;
`else
    if (dx > cur_x)      raw_port = P_E;
    else if (dx < cur_x) raw_port = P_W;
    else if (dy > cur_y) raw_port = P_N;
    else if (dy < cur_y) raw_port = P_S;
`endif
    route_err = (raw_port == DIR_PORT);
    calc_port = route_err ? P_L : raw_port;
  end

  always_comb begin
    cur_busy  = 1'b0;
    held_port = '0;
    for (int unsigned v = 0; v < VCN; v++) begin
      if (in_vc[v]) begin
        cur_busy  = cur_busy | (state_q[v] == VC_BUSY);
        held_port = held_port | route_q[v];
      end
    end
  end

  always_comb begin
    emit      = 1'b0;
    bad       = 1'b0;
    store     = 1'b0;
    next_busy = cur_busy;
    sel_port  = calc_port;
    if (!vc_ok) begin
      bad = 1'b1;
    end else begin
      case (ft_e'(in_ft))
        FT_HEAD: begin
          emit      = 1'b1;
          store     = 1'b1;
          next_busy = 1'b1;
          bad       = cur_busy | route_err;
        end
        FT_SINGLE: begin
          emit      = 1'b1;
          next_busy = 1'b0;
          bad       = cur_busy | route_err;
        end
        FT_BODY: begin
          emit     = cur_busy;
          bad      = ~cur_busy;
          sel_port = held_port;
        end
        FT_TAIL: begin
          emit      = cur_busy;
          bad       = ~cur_busy;
          sel_port  = held_port;
          next_busy = 1'b0;
        end
        default: bad = 1'b1;
      endcase
    end
  end

  always_comb begin
    for (int unsigned v = 0; v < VCN; v++) begin
      state_d[v] = state_q[v];
      if (xfer && vc_ok && in_vc[v])
        state_d[v] = next_busy ? VC_BUSY : VC_IDLE;
      vc_busy[v] = (state_q[v] == VC_BUSY);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned v = 0; v < VCN; v++) begin
        state_q[v] <= VC_IDLE;
        route_q[v] <= '0;
      end
    end else begin
      for (int unsigned v = 0; v < VCN; v++) begin
        state_q[v] <= state_d[v];
        if (xfer && vc_ok && store && in_vc[v])
          route_q[v] <= calc_port;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_vld  <= 1'b0;
      out_vc   <= '0;
      out_ft   <= '0;
      out_data <= '0;
      out_port <= '0;
      err      <= 1'b0;
    end else begin
      err <= xfer & bad;
      if (in_rdy) begin
        out_vld <= xfer & emit;
        if (xfer && emit) begin
          out_vc   <= in_vc;
          out_ft   <= in_ft;
          out_data <= in_data;
          out_port <= sel_port;
        end
      end
    end
  end

endmodule

// File: tb/tb_rtu_sync.sv
// Directed bench for rtu_sync: scoreboard of expected output flits plus
// direct checks of err, vc_busy, backpressure and asynchronous reset.
module tb_rtu_sync;

  localparam logic [1:0] FT_BODY   = 2'd0;
  localparam logic [1:0] FT_HEAD   = 2'd1;
  localparam logic [1:0] FT_TAIL   = 2'd2;
  localparam logic [1:0] FT_SINGLE = 2'd3;
  localparam logic [4:0] P_S = 5'b00001;
  localparam logic [4:0] P_W = 5'b00010;
  localparam logic [4:0] P_N = 5'b00100;
  localparam logic [4:0] P_E = 5'b01000;
  localparam logic [4:0] P_L = 5'b10000;

  logic        clk = 1'b0;
  logic        rstn;
  logic [7:0]  cur_x, cur_y;
  logic        in_vld, out_rdy;
  logic [1:0]  in_vc, in_ft;
  logic [31:0] in_data;

  logic        in_rdy, out_vld, err;
  logic [1:0]  out_vc, out_ft, vc_busy;
  logic [31:0] out_data;
  logic [4:0]  out_port;

  logic        e_in_rdy, e_out_vld, e_err;
  logic [1:0]  e_out_vc, e_out_ft, e_vc_busy;
  logic [31:0] e_out_data;
  logic [4:0]  e_out_port;

  typedef struct {
    logic [1:0]  vc;
    logic [1:0]  ft;
    logic [31:0] data;
    logic [4:0]  port;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rtu_sync #(.VCN(2), .AW(8), .DW(32), .DIR(4)) u_dut (
    .clk(clk), .rstn(rstn), .cur_x(cur_x), .cur_y(cur_y),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_vc(in_vc), .in_ft(in_ft), .in_data(in_data),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_vc(out_vc), .out_ft(out_ft),
    .out_data(out_data), .out_port(out_port), .err(err), .vc_busy(vc_busy)
  );

  rtu_sync #(.VCN(2), .AW(8), .DW(32), .DIR(3)) u_east (
    .clk(clk), .rstn(rstn), .cur_x(cur_x), .cur_y(cur_y),
    .in_vld(in_vld), .in_rdy(e_in_rdy), .in_vc(in_vc), .in_ft(in_ft), .in_data(in_data),
    .out_vld(e_out_vld), .out_rdy(out_rdy), .out_vc(e_out_vc), .out_ft(e_out_ft),
    .out_data(e_out_data), .out_port(e_out_port), .err(e_err), .vc_busy(e_vc_busy)
  );

  task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [7:0] tag, input logic [7:0] x, input logic [7:0] y);
    return {8'hA5, tag, y, x};
  endfunction

  // Drives one flit, waits (bounded) for the transfer, checks err one cycle later.
  task automatic send(input string nm, input logic [1:0] vc, input logic [1:0] ft,
                      input logic [31:0] d, input bit emit, input logic [4:0] port,
                      input logic exp_err);
    int n = 0;
    in_vld = 1'b1; in_vc = vc; in_ft = ft; in_data = d;
    while (!in_rdy && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 20) begin
      chk({nm, "_rdy_timeout"}, 32'(in_rdy), 32'd1);
      in_vld = 1'b0;
      return;
    end
    if (emit) sb.push_back('{vc, ft, d, port});
    @(posedge clk); #1;
    in_vld = 1'b0;
    chk({nm, "_err"}, 32'(err), 32'(exp_err));
  endtask

  always @(negedge clk) begin
    if (rstn && out_vld && out_rdy) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", 32'(out_vld), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_vc", 32'(out_vc), 32'(e.vc));
        chk("out_ft", 32'(out_ft), 32'(e.ft));
        chk("out_data", out_data, e.data);
        chk("out_port", 32'(out_port), 32'(e.port));
      end
    end
  end

  initial begin
    #500000;
    $error("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0; cur_x = 8'd3; cur_y = 8'd3;
    in_vld = 1'b0; in_vc = '0; in_ft = '0; in_data = '0; out_rdy = 1'b1;
    #2;
    chk("rst_out_vld", 32'(out_vld), 32'd0);
    chk("rst_out_port", 32'(out_port), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_vc_busy", 32'(vc_busy), 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;

    // Packet on VC0 toward (5,1): east on every flit, body payload ignored for route
    send("t1_head", 2'b01, FT_HEAD, mk(8'h01, 8'd5, 8'd1), 1, P_E, 1'b0);
    chk("t1_busy_head", 32'(vc_busy), 32'b01);
    send("t1_body", 2'b01, FT_BODY, mk(8'h02, 8'd0, 8'd0), 1, P_E, 1'b0);
    send("t1_tail", 2'b01, FT_TAIL, mk(8'h03, 8'd0, 8'd7), 1, P_E, 1'b0);
    chk("t1_busy_tail", 32'(vc_busy), 32'b00);
    @(posedge clk); #1;

    // East input, destination further east: U-turn on DIR=3, plain E on DIR=4
    send("t2_single", 2'b01, FT_SINGLE, mk(8'h10, 8'd7, 8'd3), 1, P_E, 1'b0);
    chk("t2_east_port", 32'(e_out_port), 32'(P_L));
    chk("t2_east_err", 32'(e_err), 32'd1);
    @(posedge clk); #1;
    chk("t2_east_err_pulse", 32'(e_err), 32'd0);

    // Local-to-local on local input
    send("t2_local", 2'b01, FT_SINGLE, mk(8'h11, 8'd3, 8'd3), 1, P_L, 1'b1);
    @(posedge clk); #1;
    chk("t2_local_err_pulse", 32'(err), 32'd0);

    // Interleaved VCs with independent held routes
    send("t3_h0", 2'b01, FT_HEAD, mk(8'h20, 8'd3, 8'd0), 1, P_S, 1'b0);
    send("t3_h1", 2'b10, FT_HEAD, mk(8'h21, 8'd0, 8'd3), 1, P_W, 1'b0);
    chk("t3_busy", 32'(vc_busy), 32'b11);
    send("t3_b0", 2'b01, FT_BODY, mk(8'h22, 8'd7, 8'd7), 1, P_S, 1'b0);
    send("t3_b1", 2'b10, FT_BODY, mk(8'h23, 8'd7, 8'd7), 1, P_W, 1'b0);
    send("t3_t0", 2'b01, FT_TAIL, mk(8'h24, 8'd7, 8'd7), 1, P_S, 1'b0);
    send("t3_t1", 2'b10, FT_TAIL, mk(8'h25, 8'd7, 8'd7), 1, P_W, 1'b0);
    chk("t3_idle", 32'(vc_busy), 32'b00);
    @(posedge clk); #1;

    // Backpressure: output held for 4 cycles, next flit one cycle after release
    out_rdy = 1'b0;
    send("t4_a", 2'b01, FT_SINGLE, mk(8'h30, 8'd3, 8'd5), 1, P_N, 1'b0);
    in_vld = 1'b1; in_vc = 2'b10; in_ft = FT_SINGLE; in_data = mk(8'h31, 8'd1, 8'd3);
    for (int i = 0; i < 4; i++) begin
      chk("t4_in_rdy", 32'(in_rdy), 32'd0);
      chk("t4_hold_vld", 32'(out_vld), 32'd1);
      chk("t4_hold_data", out_data, mk(8'h30, 8'd3, 8'd5));
      chk("t4_hold_port", 32'(out_port), 32'(P_N));
      @(posedge clk); #1;
    end
    out_rdy = 1'b1;
    sb.push_back('{2'b10, FT_SINGLE, mk(8'h31, 8'd1, 8'd3), P_W});
    @(posedge clk); #1;
    in_vld = 1'b0;
    chk("t4_next_data", out_data, mk(8'h31, 8'd1, 8'd3));
    chk("t4_next_port", 32'(out_port), 32'(P_W));
    @(posedge clk); #1;

    // Head on busy VC reroutes with error; non-one-hot VCs are dropped
    send("t5_h", 2'b01, FT_HEAD, mk(8'h40, 8'd5, 8'd1), 1, P_E, 1'b0);
    send("t5_h2", 2'b01, FT_HEAD, mk(8'h41, 8'd3, 8'd5), 1, P_N, 1'b1);
    send("t5_b", 2'b01, FT_BODY, mk(8'h42, 8'd0, 8'd0), 1, P_N, 1'b0);
    send("t5_vc11", 2'b11, FT_HEAD, mk(8'h43, 8'd0, 8'd0), 0, P_L, 1'b1);
    send("t5_vc00", 2'b00, FT_TAIL, mk(8'h44, 8'd0, 8'd0), 0, P_L, 1'b1);
    chk("t5_busy_kept", 32'(vc_busy), 32'b01);
    send("t5_t", 2'b01, FT_TAIL, mk(8'h45, 8'd0, 8'd0), 1, P_N, 1'b0);
    chk("t5_idle", 32'(vc_busy), 32'b00);
    @(posedge clk); #1;

    // Body on idle VC1 is dropped with error
    send("t6_drop", 2'b10, FT_BODY, mk(8'h50, 8'd5, 8'd5), 0, P_L, 1'b1);
    chk("t6_no_vld", 32'(out_vld), 32'd0);

    // Async reset mid-packet on VC0 with output stalled
    out_rdy = 1'b0;
    send("t6_head", 2'b01, FT_HEAD, mk(8'h51, 8'd5, 8'd1), 1, P_E, 1'b0);
    chk("t6_busy", 32'(vc_busy), 32'b01);
    chk("t6_vld", 32'(out_vld), 32'd1);
    #3;
    rstn = 1'b0;
    sb.delete();
    #1;
    chk("t6_rst_busy", 32'(vc_busy), 32'b00);
    chk("t6_rst_vld", 32'(out_vld), 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    out_rdy = 1'b1;
    send("t6_body_after_rst", 2'b01, FT_BODY, mk(8'h52, 8'd5, 8'd1), 0, P_L, 1'b1);
    chk("t6_after_vld", 32'(out_vld), 32'd0);

    // Routing order: (5,6) from (3,3)
`ifdef RTU_YX_ROUTING_EN
    send("t7_order", 2'b10, FT_SINGLE, mk(8'h60, 8'd5, 8'd6), 1, P_N, 1'b0);
`else
    send("t7_order", 2'b10, FT_SINGLE, mk(8'h60, 8'd5, 8'd6), 1, P_E, 1'b0);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
